fpu_xif_result_buffer: RTL
==========================

// Module: fpu_xif_result_buffer
// PURPOSE
//  Writeback-side stage of the FP coprocessor, sitting between the execution pipeline and the CORE-V-XIF
//  result interface. Buffers completed results (id, rd, data) in order in a FIFO and gates each one on
//  the XIF commit interface. Only committed results are presented on result_*; killed results are
//  dropped silently. Preserves XIF result-handshake rules: no retraction, stable payload while stalled.
// PARAMETERS
//  X_ID_WIDTH   4   width of XIF instruction id; a commit-flag table holds 2**X_ID_WIDTH entries
//  X_RFW_WIDTH  32  result data width (FLEN)
//  DEPTH        4   FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1            clock; all state updates on rising edge
//  rst_n         in   1            synchronous reset, active low
//  in_valid      in   1            pipeline has a completed result
//  in_ready      out  1            buffer can accept a result
//  in_id         in   X_ID_WIDTH   id of completed instruction
//  in_rd         in   5            destination register
//  in_data       in   X_RFW_WIDTH  result value
//  commit_valid  in   1            XIF commit strobe
//  commit_id     in   X_ID_WIDTH   id being committed or killed
//  commit_kill   in   1            1 = kill, 0 = commit
//  result_valid  out  1            XIF result valid
//  result_ready  in   1            XIF result ready from core
//  result_id     out  X_ID_WIDTH   head entry id
//  result_rd     out  5            head entry rd
//  result_data   out  X_RFW_WIDTH  head entry data
//  count         out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): wr/rd pointers=0, count=0, all commit/kill flags=0. Outputs: result_valid=0,
//    in_ready=1, result_id/rd/data=0. Reset mid-operation discards all entries and flags; no result escapes.
//  - Storage: DEPTH-entry circular FIFO. Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//    count is tracked separately and distinguishes full from empty.
//  - Push: in_valid & in_ready writes {id,rd,data} at wr_ptr; wr_ptr++. in_ready = (count != DEPTH), from
//    registered state only. No push while full, even if a pop happens in the same cycle.
//  - Commit table: per id, flags cmt[id] and kil[id].
//    On commit_valid: commit_kill=0 sets cmt[commit_id]; commit_kill=1 sets kil[commit_id].
//    The flags take effect the next cycle. A commit may precede or follow the result push.
//  - Head state, when count>0, decided each cycle from registered state:
//      WAIT : neither flag set -> result_valid=0, hold.
//      SEND : cmt set -> result_valid=1, payload = head entry. Pop when result_ready=1.
//      DROP : kil set -> result_valid=0, pop unconditionally this cycle.
//  - Pop: rd_ptr++, and clear cmt/kil of the popped id in the same edge.
//    If a commit_valid for that same id arrives in the pop cycle, it is a protocol error (id reuse
//    before retire); the clear wins.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    Simultaneous commit of a different id and pop: both take effect.
//  - Latency, push at edge N:
//      entry is head and cmt already set -> result_valid at cycle N+1;
//      commit in cycle N -> result_valid at N+1;
//      commit later at cycle M -> result_valid at M+1.
//    Throughput: 1 result/cycle when committed and result_ready=1. A killed head costs 1 cycle.
//  - Once result_valid=1, it and result_id/rd/data stay stable until result_ready=1.
//    Non-head entries never bypass the head: strict in-order output.
//  - Payload outputs are driven from the head entry even when result_valid=0.
// TESTING
//  1. Reset then push id=3,rd=5,data=0x3F800000 and commit id=3 in the same cycle
//     -> result_valid=1 next cycle with id 3, rd 5, that data; pop with ready=1 -> count 0.
//  2. Push id=1, commit id=1 arrives 4 cycles later -> result_valid stays 0 until the cycle after commit.
//  3. Push ids 0,1,2; kill 1; commit 0,2; result_ready=1 -> output order 0 then 2, no valid for 1, count ends 0.
//  4. DEPTH=4, result_ready=0, push 5 results -> in_ready=0 after 4th, 5th held.
//     Commit all, ready=1 -> 5th accepted, pointers wrap, outputs in order.
//  5. Committed head with result_ready=0 for 3 cycles -> valid and payload constant,
//     then popped on the first ready cycle.
//  6. Assert rst_n=0 with 3 committed entries buffered -> next cycle result_valid=0,
//     count=0, in_ready=1; a later push of the same ids waits for fresh commits.

Source files
------------

// File: rtl/fpu_xif_result_buffer_if.sv
// fpu_xif_result_buffer_if: pipeline-in, commit and XIF result channels of the result buffer.
// Master is the surrounding system (pipeline, core); slave is the buffer itself.
interface fpu_xif_result_buffer_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [X_ID_WIDTH-1:0]    in_id;
  logic [4:0]               in_rd;
  logic [X_RFW_WIDTH-1:0]   in_data;
  logic                     commit_valid;
  logic [X_ID_WIDTH-1:0]    commit_id;
  logic                     commit_kill;
  logic                     result_valid;
  logic                     result_ready;
  logic [X_ID_WIDTH-1:0]    result_id;
  logic [4:0]               result_rd;
  logic [X_RFW_WIDTH-1:0]   result_data;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output in_valid, in_id, in_rd, in_data, commit_valid, commit_id, commit_kill, result_ready,
    input  in_ready, result_valid, result_id, result_rd, result_data, count
  );
  modport slave (
    input  in_valid, in_id, in_rd, in_data, commit_valid, commit_id, commit_kill, result_ready,
    output in_ready, result_valid, result_id, result_rd, result_data, count
  );
endinterface

// File: rtl/fpu_xif_result_buffer.sv
// fpu_xif_result_buffer: in-order FIFO of completed FP results, each released to XIF only once committed.
// Killed heads are retired silently in one cycle; committed heads wait for result_ready.
module fpu_xif_result_buffer #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fpu_xif_result_buffer_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int NID = 2 ** X_ID_WIDTH;
  logic [X_ID_WIDTH-1:0]  mem_id   [DEPTH];
  logic [4:0]             mem_rd   [DEPTH];
  logic [X_RFW_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            cnt;
  logic [NID-1:0]         cmt, kil;
  logic [X_ID_WIDTH-1:0]  head_id;
  logic                   busy, send, drop, push, pop;
  always_comb begin
    head_id = mem_id[rd_ptr];
    busy    = cnt != '0;
    send    = busy & cmt[head_id];
    drop    = busy & ~cmt[head_id] & kil[head_id];
    push    = bus.in_valid & bus.in_ready;
    pop     = (send & bus.result_ready) | drop;
  end
  assign bus.in_ready     = cnt != (PW+1)'(DEPTH);
  assign bus.result_valid = send;
  assign bus.result_id    = head_id;
  assign bus.result_rd    = mem_rd[rd_ptr];
  assign bus.result_data  = mem_data[rd_ptr];
  assign bus.count        = cnt;
  // Storage is cleared on reset so the payload outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      cmt    <= '0;
      kil    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_id[wr_ptr]   <= bus.in_id;
        mem_rd[wr_ptr]   <= bus.in_rd;
        mem_data[wr_ptr] <= bus.in_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (bus.commit_valid && !bus.commit_kill) cmt[bus.commit_id] <= 1'b1;
      if (bus.commit_valid && bus.commit_kill) kil[bus.commit_id] <= 1'b1;
      // Retiring clears the flags last so a same-cycle commit of a reused id loses.
      if (pop) begin
        cmt[head_id] <= 1'b0;
        kil[head_id] <= 1'b0;
      end
    end
  end
endmodule
